// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller.
package mc_controller_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
    localparam logic [6:0] F7MulDiv = 7'b0000001;

    localparam logic [31:0] InstEcall  = 32'h0000_0073;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;

    // Nine states do not fit in three bits, so the debug state bus is four wide.
    localparam int unsigned StateW = 4;

    typedef enum logic [StateW-1:0] {
        StFetch  = 4'd0,
        StWaitI  = 4'd1,
        StDecode = 4'd2,
        StExec   = 4'd3,
        StMem    = 4'd4,
        StWaitD  = 4'd5,
        StMdiv   = 4'd6,
        StWb     = 4'd7,
        StHalt   = 4'd8
    } state_e;

    typedef enum logic [1:0] {WbAlu = 2'd0, WbMem = 2'd1, WbPc4 = 2'd2} wb_sel_e;

    typedef enum logic [2:0] {
        ImmI = 3'd0, ImmS = 3'd1, ImmB = 3'd2, ImmU = 3'd3, ImmJ = 3'd4
    } imm_sel_e;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0, AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3, AluSltu = 4'd4,
        AluXor  = 4'd5, AluSrl = 4'd6, AluSra = 4'd7, AluOr  = 4'd8, AluAnd  = 4'd9
    } alu_sel_e;

    typedef struct packed {
        logic     asel;
        logic     bsel;
        logic     br_un;
        logic     force_rs1_zero;
        wb_sel_e  wb_sel;
        imm_sel_e imm_sel;
        alu_sel_e alu_sel;
        logic [2:0] funct3;
        logic     reg_wen;
        logic     is_store;
        logic     is_branch;
        logic     is_jump;
        logic     is_mem;
        logic     is_muldiv;
    } ctrl_t;

    function automatic alu_sel_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        unique case (funct3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    // funct3[2] selects the less-than family, funct3[0] inverts the condition.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic br_eq,
                                          input logic br_lt);
        logic cond;
        cond = funct3[2] ? br_lt : br_eq;
        return cond ^ funct3[0];
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Fetch, data-memory and mul/div handshakes between the controller and its neighbours.
interface mc_controller_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] inst;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        muldiv_start;
    logic        muldiv_done;

    modport master (
        output if_req_valid, lsu_req_valid, muldiv_start,
        input  if_req_ready, if_rsp_valid, inst, lsu_req_ready, lsu_rsp_valid, muldiv_done
    );

    modport slave (
        input  if_req_valid, lsu_req_valid, muldiv_start,
        output if_req_ready, if_rsp_valid, inst, lsu_req_ready, lsu_rsp_valid, muldiv_done
    );
endinterface

// File: rtl/mc_decoder.sv
// Combinational RV32I(M) decode of the instruction register into a control bundle.
module mc_decoder
    import mc_controller_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0,
    parameter bit RV32E    = 1'b0
) (
    input  logic [31:0] ir_i,
    output ctrl_t       ctrl_o,
    output logic        is_trap_o,
    output logic        is_illegal_o,
    output logic        is_mem_o,
    output logic        is_muldiv_o
);

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       uses_rd, uses_rs1, uses_rs2;
    logic       illegal;
    ctrl_t      ctrl;

    assign opcode = ir_i[6:0];
    assign rd     = ir_i[11:7];
    assign funct3 = ir_i[14:12];
    assign rs1    = ir_i[19:15];
    assign rs2    = ir_i[24:20];
    assign funct7 = ir_i[31:25];

    // Decode opcode class, datapath selects and legality.
    always_comb begin
        ctrl        = '0;
        ctrl.funct3 = funct3;
        illegal     = 1'b0;
        is_trap_o   = 1'b0;
        uses_rd     = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        case (opcode)
            OpLui, OpAuipc: begin
                ctrl.imm_sel        = ImmU;
                ctrl.bsel           = 1'b1;
                ctrl.asel           = (opcode == OpAuipc);
                ctrl.force_rs1_zero = 1'b1;
                ctrl.reg_wen        = 1'b1;
                uses_rd             = 1'b1;
            end
            OpJal: begin
                ctrl.imm_sel = ImmJ;
                ctrl.asel    = 1'b1;
                ctrl.bsel    = 1'b1;
                ctrl.wb_sel  = WbPc4;
                ctrl.is_jump = 1'b1;
                ctrl.reg_wen = 1'b1;
                uses_rd      = 1'b1;
            end
            OpJalr: begin
                ctrl.imm_sel = ImmI;
                ctrl.bsel    = 1'b1;
                ctrl.wb_sel  = WbPc4;
                ctrl.is_jump = 1'b1;
                ctrl.reg_wen = 1'b1;
                uses_rd      = 1'b1;
                uses_rs1     = 1'b1;
                illegal      = (funct3 != 3'b000);
            end
            OpBranch: begin
                ctrl.imm_sel   = ImmB;
                ctrl.asel      = 1'b1;
                ctrl.bsel      = 1'b1;
                ctrl.br_un     = funct3[1];
                ctrl.is_branch = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                illegal        = (funct3[2:1] == 2'b01);
            end
            OpLoad: begin
                ctrl.imm_sel = ImmI;
                ctrl.bsel    = 1'b1;
                ctrl.wb_sel  = WbMem;
                ctrl.is_mem  = 1'b1;
                ctrl.reg_wen = 1'b1;
                uses_rd      = 1'b1;
                uses_rs1     = 1'b1;
                illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OpStore: begin
                ctrl.imm_sel  = ImmS;
                ctrl.bsel     = 1'b1;
                ctrl.is_mem   = 1'b1;
                ctrl.is_store = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                illegal       = (funct3[2] || funct3 == 3'b011);
            end
            OpOpImm: begin
                ctrl.imm_sel = ImmI;
                ctrl.bsel    = 1'b1;
                ctrl.reg_wen = 1'b1;
                ctrl.alu_sel = alu_from_funct3(funct3, funct3 == 3'b101 && funct7 == F7Alt);
                uses_rd      = 1'b1;
                uses_rs1     = 1'b1;
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7Base);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != F7Base) && (funct7 != F7Alt);
                end
            end
            OpOp: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (funct7 == F7MulDiv) begin
                    ctrl.is_muldiv = ENABLE_M;
                    ctrl.reg_wen   = 1'b1;
                    illegal        = !ENABLE_M;
                end else if (funct7 == F7Base ||
                             (funct7 == F7Alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    ctrl.alu_sel = alu_from_funct3(funct3, funct7 == F7Alt);
                    ctrl.reg_wen = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OpSystem: begin
                if (ir_i == InstEcall || ir_i == InstEbreak) begin
                    is_trap_o = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        // Only fields the format actually encodes count against the 16-register limit.
        if (RV32E && ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]))) begin
            illegal = 1'b1;
        end
    end

    assign ctrl_o       = ctrl;
    assign is_illegal_o = illegal;
    assign is_mem_o     = ctrl.is_mem;
    assign is_muldiv_o  = ctrl.is_muldiv;

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I controller: FSM, instruction register and registered control bundle.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0,
    parameter bit RV32E    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_controller_if.master   bus,
    input  logic              BrEq,
    input  logic              BrLT,
    output logic              IRWEn,
    output logic              PCWEn,
    output logic              RegWEn,
    output logic              DMWen,
    output logic              Asel,
    output logic              Bsel,
    output logic              BrUn,
    output logic              PCSel,
    output logic              ForceRs1ToZero,
    output logic [1:0]        WBSel,
    output logic [2:0]        ImmSel,
    output logic [3:0]        ALUSel,
    output logic [2:0]        MulDivOp,
    output logic              retire,
    output logic              halt,
    output logic              illegal,
    output logic [StateW-1:0] state
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        halt_q, halt_d;
    logic        illegal_q, illegal_d;

    ctrl_t dec_ctrl;
    logic  dec_trap, dec_illegal, dec_mem, dec_muldiv;

    mc_decoder #(
        .ENABLE_M (ENABLE_M),
        .RV32E    (RV32E)
    ) u_decoder (
        .ir_i         (ir_q),
        .ctrl_o       (dec_ctrl),
        .is_trap_o    (dec_trap),
        .is_illegal_o (dec_illegal),
        .is_mem_o     (dec_mem),
        .is_muldiv_o  (dec_muldiv)
    );

    // Next-state logic; controls are captured only on the way into EXEC.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ctrl_d    = ctrl_q;
        halt_d    = halt_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StFetch:  if (bus.if_req_ready) state_d = StWaitI;
            StWaitI: begin
                if (bus.if_rsp_valid) begin
                    ir_d    = bus.inst;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_illegal) begin
                    halt_d    = 1'b1;
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else if (dec_trap) begin
                    halt_d  = 1'b1;
                    state_d = StHalt;
                end else begin
                    ctrl_d  = dec_ctrl;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (ctrl_q.is_mem)         state_d = StMem;
                else if (ctrl_q.is_muldiv) state_d = StMdiv;
                else                       state_d = StWb;
            end
            StMem:    if (bus.lsu_req_ready) state_d = StWaitD;
            StWaitD:  if (bus.lsu_rsp_valid) state_d = StWb;
            StMdiv:   if (bus.muldiv_done)   state_d = StWb;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // State, IR, control and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            ir_q      <= '0;
            ctrl_q    <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ctrl_q    <= ctrl_d;
            halt_q    <= halt_d;
            illegal_q <= illegal_d;
        end
    end

    logic in_wb;
    assign in_wb = (state_q == StWb);

    // Strobes decoded from the registered state; fetch request is masked while in reset.
    always_comb begin
        bus.if_req_valid  = rst_n && (state_q == StFetch);
        bus.lsu_req_valid = (state_q == StMem);
        bus.muldiv_start  = ENABLE_M && (state_q == StExec) && ctrl_q.is_muldiv;
        IRWEn             = (state_q == StWaitI) && bus.if_rsp_valid;
        DMWen             = (state_q == StMem) && ctrl_q.is_store;
        PCWEn             = in_wb;
        retire            = in_wb;
        RegWEn            = in_wb && ctrl_q.reg_wen;
        PCSel             = in_wb && (ctrl_q.is_jump ||
                            (ctrl_q.is_branch && branch_taken(ctrl_q.funct3, BrEq, BrLT)));
    end

    assign Asel           = ctrl_q.asel;
    assign Bsel           = ctrl_q.bsel;
    assign BrUn           = ctrl_q.br_un;
    assign ForceRs1ToZero = ctrl_q.force_rs1_zero;
    assign WBSel          = ctrl_q.wb_sel;
    assign ImmSel         = ctrl_q.imm_sel;
    assign ALUSel         = ctrl_q.alu_sel;
    assign MulDivOp       = ctrl_q.is_muldiv ? ctrl_q.funct3 : 3'b000;
    assign halt           = halt_q;
    assign illegal        = illegal_q;
    assign state          = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: vector table plus multi-cycle hand sequences.
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic clk, rst_n, BrEq, BrLT;
    logic IRWEn, PCWEn, RegWEn, DMWen, Asel, Bsel, BrUn, PCSel, ForceRs1ToZero;
    logic [1:0] WBSel;
    logic [2:0] ImmSel, MulDivOp;
    logic [3:0] ALUSel, state;
    logic retire, halt, illegal;

    int n_checks = 0;
    int n_errors = 0;

    mc_controller_if bus ();
    mc_controller #(.ENABLE_M(1'b1), .RV32E(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .BrEq(BrEq), .BrLT(BrLT),
        .IRWEn(IRWEn), .PCWEn(PCWEn), .RegWEn(RegWEn), .DMWen(DMWen), .Asel(Asel),
        .Bsel(Bsel), .BrUn(BrUn), .PCSel(PCSel), .ForceRs1ToZero(ForceRs1ToZero),
        .WBSel(WBSel), .ImmSel(ImmSel), .ALUSel(ALUSel), .MulDivOp(MulDivOp),
        .retire(retire), .halt(halt), .illegal(illegal), .state(state)
    );

    // Two side instances with constant stimulus: M disabled, and RV32E enabled.
    logic [8:0] n_misc, e_misc;
    logic [1:0] n_wb, e_wb;
    logic [2:0] n_imm, n_mdo, e_imm, e_mdo;
    logic [3:0] n_alu, n_st, e_alu, e_st;
    logic n_halt, n_ill, n_ret, e_halt, e_ill, e_ret;

    mc_controller_if bus_n ();
    assign bus_n.if_req_ready = 1'b1;
    assign bus_n.if_rsp_valid = 1'b1;
    assign bus_n.inst = 32'h0220_8133;
    assign bus_n.lsu_req_ready = 1'b0;
    assign bus_n.lsu_rsp_valid = 1'b0;
    assign bus_n.muldiv_done = 1'b0;
    mc_controller #(.ENABLE_M(1'b0), .RV32E(1'b0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .bus(bus_n), .BrEq(1'b0), .BrLT(1'b0),
        .IRWEn(n_misc[0]), .PCWEn(n_misc[1]), .RegWEn(n_misc[2]), .DMWen(n_misc[3]),
        .Asel(n_misc[4]), .Bsel(n_misc[5]), .BrUn(n_misc[6]), .PCSel(n_misc[7]),
        .ForceRs1ToZero(n_misc[8]), .WBSel(n_wb), .ImmSel(n_imm), .ALUSel(n_alu),
        .MulDivOp(n_mdo), .retire(n_ret), .halt(n_halt), .illegal(n_ill), .state(n_st)
    );

    mc_controller_if bus_e ();
    assign bus_e.if_req_ready = 1'b1;
    assign bus_e.if_rsp_valid = 1'b1;
    assign bus_e.inst = 32'h0000_0833;
    assign bus_e.lsu_req_ready = 1'b0;
    assign bus_e.lsu_rsp_valid = 1'b0;
    assign bus_e.muldiv_done = 1'b0;
    mc_controller #(.ENABLE_M(1'b1), .RV32E(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .bus(bus_e), .BrEq(1'b0), .BrLT(1'b0),
        .IRWEn(e_misc[0]), .PCWEn(e_misc[1]), .RegWEn(e_misc[2]), .DMWen(e_misc[3]),
        .Asel(e_misc[4]), .Bsel(e_misc[5]), .BrUn(e_misc[6]), .PCSel(e_misc[7]),
        .ForceRs1ToZero(e_misc[8]), .WBSel(e_wb), .ImmSel(e_imm), .ALUSel(e_alu),
        .MulDivOp(e_mdo), .retire(e_ret), .halt(e_halt), .illegal(e_ill), .state(e_st)
    );

    logic [63:0] all_outs;
    assign all_outs = {bus.if_req_valid, bus.lsu_req_valid, bus.muldiv_start, IRWEn, PCWEn,
                       RegWEn, DMWen, Asel, Bsel, BrUn, PCSel, ForceRs1ToZero, WBSel, ImmSel,
                       ALUSel, MulDivOp, retire, halt, illegal, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] ctl(input logic regwen, pcsel, asel, bsel, brun, frc,
                                        input logic [1:0] wb, input logic [2:0] imm,
                                        input logic [3:0] alu);
        return {regwen, pcsel, asel, bsel, brun, frc, wb, imm, alu};
    endfunction

    // Results of the last run_instr call.
    int r_ifreq_first, r_irwen_cyc, r_wb_cyc, r_halt_cyc;
    int r_lsu_cnt, r_dmw_cnt, r_waitd_cnt, r_mds_cnt, r_mdiv_cnt;
    logic [14:0] s_ctl;
    logic [2:0]  s_mdop;
    logic        s_pcwen, s_illegal;

    // Plays the memories and mul/div unit for one instruction, starting at a negedge
    // with the DUT in FETCH. Cycle 1 is the FETCH cycle.
    task automatic run_instr(input logic [31:0] instr, input logic br_eq, input logic br_lt,
                             input int lsu_rdy_dly, input int lsu_rsp_dly, input int md_lat,
                             input int rst_at);
        bit if_pend = 0, lsu_pend = 0, md_pend = 0, done = 0;
        int lsu_req_n = 0, lsu_rsp_n = 0, md_n = 0;
        r_ifreq_first = 0; r_irwen_cyc = 0; r_wb_cyc = 0; r_halt_cyc = 0;
        r_lsu_cnt = 0; r_dmw_cnt = 0; r_waitd_cnt = 0; r_mds_cnt = 0; r_mdiv_cnt = 0;
        s_ctl = '0; s_mdop = '0; s_pcwen = 0; s_illegal = 0;
        BrEq = br_eq;
        BrLT = br_lt;
        for (int c = 1; c <= 80 && !done; c++) begin
            bus.if_req_ready = 1'b1;
            bus.if_rsp_valid = if_pend;
            bus.inst = if_pend ? instr : 32'hDEAD_BEEF;
            if (bus.lsu_req_valid) lsu_req_n++;
            bus.lsu_req_ready = bus.lsu_req_valid && (lsu_req_n > lsu_rdy_dly);
            if (lsu_pend) lsu_rsp_n++;
            bus.lsu_rsp_valid = lsu_pend && (lsu_rsp_n >= lsu_rsp_dly);
            if (md_pend) md_n++;
            bus.muldiv_done = md_pend && (md_n >= md_lat);
            #1;
            if (bus.if_req_valid && r_ifreq_first == 0) r_ifreq_first = c;
            if (IRWEn && r_irwen_cyc == 0) r_irwen_cyc = c;
            if (bus.lsu_req_valid) r_lsu_cnt++;
            if (DMWen) r_dmw_cnt++;
            if (state == StWaitD) r_waitd_cnt++;
            if (bus.muldiv_start) r_mds_cnt++;
            if (state == StMdiv) r_mdiv_cnt++;
            if (retire) begin
                s_ctl = {RegWEn, PCSel, Asel, Bsel, BrUn, ForceRs1ToZero, WBSel, ImmSel, ALUSel};
                s_mdop = MulDivOp;
                s_pcwen = PCWEn;
                r_wb_cyc = c;
                done = 1;
            end
            if (halt) begin
                r_halt_cyc = c;
                s_illegal = illegal;
                done = 1;
            end
            if (c == rst_at) begin
                chk("rst_in_mem_req_valid", bus.lsu_req_valid, 1);
                rst_n = 1'b0;
                #1;
                chk("rst_in_mem_outputs", all_outs, 0);
                done = 1;
            end
            if (bus.if_rsp_valid) if_pend = 0;
            if (bus.if_req_valid && bus.if_req_ready) if_pend = 1;
            if (bus.lsu_rsp_valid) lsu_pend = 0;
            if (bus.lsu_req_valid && bus.lsu_req_ready) begin lsu_pend = 1; lsu_rsp_n = 0; end
            if (bus.muldiv_done) md_pend = 0;
            if (bus.muldiv_start) begin md_pend = 1; md_n = 0; end
            @(negedge clk);
        end
        if (!done) chk("run_bound", 0, 1);
        bus.if_rsp_valid = 0; bus.lsu_req_ready = 0; bus.lsu_rsp_valid = 0; bus.muldiv_done = 0;
    endtask

    task automatic watch_halted(input string name);
        int n = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (bus.if_req_valid) n++;
        end
        chk({name, "_no_fetch"}, n, 0);
        chk({name, "_halt_held"}, halt, 1);
    endtask

    typedef struct {
        logic [31:0] inst;
        logic        eq;
        logic        lt;
        int          cycles;
        int          lsu;
        int          dmw;
        logic [14:0] ctl;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h0050_0093, 0, 0, 5, 0, 0, ctl(1, 0, 0, 1, 0, 0, WbAlu, ImmI, AluAdd)};
        vecs[1]  = '{32'h0000_0463, 1, 0, 5, 0, 0, ctl(0, 1, 1, 1, 0, 0, WbAlu, ImmB, AluAdd)};
        vecs[2]  = '{32'h0000_0463, 0, 0, 5, 0, 0, ctl(0, 0, 1, 1, 0, 0, WbAlu, ImmB, AluAdd)};
        vecs[3]  = '{32'h1234_52B7, 0, 0, 5, 0, 0, ctl(1, 0, 0, 1, 0, 1, WbAlu, ImmU, AluAdd)};
        vecs[4]  = '{32'h0000_1317, 0, 0, 5, 0, 0, ctl(1, 0, 1, 1, 0, 1, WbAlu, ImmU, AluAdd)};
        vecs[5]  = '{32'h0100_00EF, 0, 0, 5, 0, 0, ctl(1, 1, 1, 1, 0, 0, WbPc4, ImmJ, AluAdd)};
        vecs[6]  = '{32'h0000_8067, 0, 0, 5, 0, 0, ctl(1, 1, 0, 1, 0, 0, WbPc4, ImmI, AluAdd)};
        vecs[7]  = '{32'h4020_81B3, 0, 0, 5, 0, 0, ctl(1, 0, 0, 0, 0, 0, WbAlu, ImmI, AluSub)};
        vecs[8]  = '{32'h0020_E463, 0, 1, 5, 0, 0, ctl(0, 1, 1, 1, 1, 0, WbAlu, ImmB, AluAdd)};
        vecs[9]  = '{32'h0020_D463, 0, 1, 5, 0, 0, ctl(0, 0, 1, 1, 0, 0, WbAlu, ImmB, AluAdd)};
        vecs[10] = '{32'h4032_5213, 0, 0, 5, 0, 0, ctl(1, 0, 0, 1, 0, 0, WbAlu, ImmI, AluSra)};
        vecs[11] = '{32'h0020_A223, 0, 0, 7, 1, 1, ctl(0, 0, 0, 1, 0, 0, WbAlu, ImmS, AluAdd)};

        rst_n = 1'b0;
        BrEq = 0; BrLT = 0;
        bus.if_req_ready = 0; bus.if_rsp_valid = 0; bus.inst = '0;
        bus.lsu_req_ready = 0; bus.lsu_rsp_valid = 0; bus.muldiv_done = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_instr(vecs[i].inst, vecs[i].eq, vecs[i].lt, 0, 1, 0, 0);
            chk({tag, "_first_if_req"}, r_ifreq_first, 1);
            chk({tag, "_irwen_cycle"}, r_irwen_cyc, 2);
            chk({tag, "_wb_cycle"}, r_wb_cyc, vecs[i].cycles);
            chk({tag, "_wb_ctl"}, s_ctl, vecs[i].ctl);
            chk({tag, "_pcwen"}, s_pcwen, 1);
            chk({tag, "_lsu_cycles"}, r_lsu_cnt, vecs[i].lsu);
            chk({tag, "_dmwen_cycles"}, r_dmw_cnt, vecs[i].dmw);
        end

        chk("nom_mul_halt", {n_halt, n_ill}, 2'b11);
        chk("rv32e_x16_halt", {e_halt, e_ill}, 2'b11);

        // lw with ready delayed two cycles and response in the third WAIT_D cycle.
        run_instr(32'h0000_A283, 0, 0, 2, 3, 0, 0);
        chk("lw_req_valid_cycles", r_lsu_cnt, 3);
        chk("lw_wait_d_cycles", r_waitd_cnt, 3);
        chk("lw_wb_cycle", r_wb_cyc, 11);
        chk("lw_wb_ctl", s_ctl, ctl(1, 0, 0, 1, 0, 0, WbMem, ImmI, AluAdd));
        chk("lw_dmwen_cycles", r_dmw_cnt, 0);

        run_instr(32'h0220_8133, 0, 0, 0, 1, 4, 0);
        chk("mul_start_pulses", r_mds_cnt, 1);
        chk("mul_mdiv_cycles", r_mdiv_cnt, 4);
        chk("mul_wb_cycle", r_wb_cyc, 9);
        chk("mul_regwen_op", {s_ctl[14], s_mdop}, {1'b1, 3'b000});

        run_instr(32'h0220_E1B3, 0, 0, 0, 1, 1, 0);
        chk("rem_wb_cycle", r_wb_cyc, 6);
        chk("rem_op", s_mdop, 3'b110);

        // Reset asserted in the second MEM cycle of a stalled load.
        run_instr(32'h0000_A283, 0, 0, 10, 1, 0, 6);
        rst_n = 1'b1;
        run_instr(32'h0050_0093, 0, 0, 0, 1, 0, 0);
        chk("post_rst_first_if_req", r_ifreq_first, 1);
        chk("post_rst_wb_cycle", r_wb_cyc, 5);

        run_instr(32'h0010_0073, 0, 0, 0, 1, 0, 0);
        chk("ebreak_halt_cycle", r_halt_cyc, 4);
        chk("ebreak_illegal", s_illegal, 0);
        watch_halted("ebreak");

        rst_n = 1'b0;
        @(negedge clk);
        chk("halt_cleared_by_reset", {halt, illegal}, 2'b00);
        rst_n = 1'b1;
        run_instr(32'h0000_0000, 0, 0, 0, 1, 0, 0);
        chk("zero_inst_halt_cycle", r_halt_cyc, 4);
        chk("zero_inst_illegal", s_illegal, 1);
        watch_halted("zero_inst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
